// File: rtl/seg_pkg.sv
// Seven-segment glyph table (a..g, bit6 = a) shared by the display encoder and seg_reader.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Returns {illegal, is_blank, bcd[3:0]}; blank and illegal patterns report bcd = 0.
    function automatic logic [5:0] seg_to_bcd(input logic [6:0] pat);
        logic [5:0] res;
        unique case (pat)
            SEG_0:     res = {2'b00, 4'd0};
            SEG_1:     res = {2'b00, 4'd1};
            SEG_2:     res = {2'b00, 4'd2};
            SEG_3:     res = {2'b00, 4'd3};
            SEG_4:     res = {2'b00, 4'd4};
            SEG_5:     res = {2'b00, 4'd5};
            SEG_6:     res = {2'b00, 4'd6};
            SEG_7:     res = {2'b00, 4'd7};
            SEG_8:     res = {2'b00, 4'd8};
            SEG_9:     res = {2'b00, 4'd9};
            SEG_BLANK: res = {2'b01, 4'd0};
            default:   res = {2'b10, 4'd0};
        endcase
        return res;
    endfunction

    // tens*10 + ones without a multiplier; at most 99 so 8 bits never overflow.
    function automatic logic [7:0] bcd2_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        return 8'({tens, 3'b000}) + 8'({tens, 1'b0}) + 8'(ones);
    endfunction

endpackage

// File: rtl/seg_reader_if.sv
// Multiplexed segment bus into seg_reader and the decoded display value out of it.
interface seg_reader_if;
    logic       sample_en;
    logic [1:0] dig_sel;
    logic [6:0] seg_in;
    logic [7:0] dec_num;
    logic       valid;
    logic       invalid;
    logic [1:0] blank;
    logic       sel_err;

    modport master (
        output sample_en, dig_sel, seg_in,
        input  dec_num, valid, invalid, blank, sel_err
    );

    modport slave (
        input  sample_en, dig_sel, seg_in,
        output dec_num, valid, invalid, blank, sel_err
    );
endinterface

// File: rtl/seg_digit_filter.sv
// Debounces one digit's segment pattern: accepts it after STABLE_CNT identical samples.
module seg_digit_filter #(
    parameter int unsigned STABLE_CNT = 3,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample,
    input  logic [6:0] seg_in,
    output logic       lock,
    output logic [6:0] lock_pat
);

    localparam logic [CNT_W-1:0] Stable = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    logic [6:0]       cand_q, cand_d;
    logic [6:0]       lock_pat_q, lock_pat_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic             lock_q, lock_d;
    logic             reach;

    always_comb begin
        cand_d     = cand_q;
        run_d      = run_q;
        lock_pat_d = lock_pat_q;
        lock_d     = 1'b0;
        reach      = 1'b0;
        if (sample) begin
            if (seg_in == cand_q) begin
                // Saturated runs have already reached the threshold once.
                if (run_q != Stable) begin
                    run_d = run_q + One;
                    reach = (run_d == Stable);
                end
            end else begin
                cand_d = seg_in;
                run_d  = One;
                reach  = (Stable == One);
            end
            if (reach && (seg_in != lock_pat_q)) begin
                lock_pat_d = seg_in;
                lock_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q     <= '0;
            run_q      <= '0;
            lock_pat_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            run_q      <= run_d;
            lock_pat_q <= lock_pat_d;
            lock_q     <= lock_d;
        end
    end

    assign lock     = lock_q;
    assign lock_pat = lock_pat_q;

endmodule

// File: rtl/seg_reader.sv
// Observes the multiplexed two-digit 7-segment bus and decodes the stable display to 0..99.
module seg_reader
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 3,
    parameter int unsigned CNT_W      = 4
) (
    input logic         clk,
    input logic         rst,
    seg_reader_if.slave bus
);

    logic       sel_onehot;
    logic [1:0] lock;
    logic [6:0] lock_pat [2];
    logic [5:0] glyph [2];

    logic [7:0] dec_q, dec_d;
    logic [3:0] val_q [2];
    logic [3:0] val_d [2];
    logic [1:0] blank_q, blank_d;
    logic       valid_q, valid_d;
    logic       invalid_q, invalid_d;
    logic       sel_err_q, sel_err_d;

    assign sel_onehot = (bus.dig_sel == 2'b01) || (bus.dig_sel == 2'b10);

    for (genvar i = 0; i < 2; i++) begin : g_digit
        seg_digit_filter #(
            .STABLE_CNT (STABLE_CNT),
            .CNT_W      (CNT_W)
        ) u_filter (
            .clk      (clk),
            .rst      (rst),
            .sample   (bus.sample_en && sel_onehot && bus.dig_sel[i]),
            .seg_in   (bus.seg_in),
            .lock     (lock[i]),
            .lock_pat (lock_pat[i])
        );
        assign glyph[i] = seg_to_bcd(lock_pat[i]);
    end

    // Only one digit is sampled per edge, so at most one lock bit is set.
    always_comb begin
        val_d     = val_q;
        blank_d   = blank_q;
        invalid_d = 1'b0;
        sel_err_d = bus.sample_en && !sel_onehot;
        for (int i = 0; i < 2; i++) begin
            if (lock[i]) begin
                if (glyph[i][5]) begin
                    invalid_d = 1'b1;
                end else begin
                    val_d[i]   = glyph[i][3:0];
                    blank_d[i] = glyph[i][4];
                end
            end
        end
        dec_d   = bcd2_to_bin(val_d[1], val_d[0]);
        valid_d = (dec_d != dec_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q     <= '0;
            val_q[0]  <= '0;
            val_q[1]  <= '0;
            blank_q   <= 2'b11;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            dec_q     <= dec_d;
            val_q     <= val_d;
            blank_q   <= blank_d;
            valid_q   <= valid_d;
            invalid_q <= invalid_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.dec_num = dec_q;
    assign bus.valid   = valid_q;
    assign bus.invalid = invalid_q;
    assign bus.blank   = blank_q;
    assign bus.sel_err = sel_err_q;

endmodule
